// File: rtl/debug_unit_fsm.sv
// Debug sequencer: turns UART command bytes into program load, free-run and
// single-step control of the CPU, and publishes its state to the display.
module debug_unit_fsm #(
  parameter int          CNT_W        = 32,
  parameter int          LOAD_TIMEOUT = 50000000,
  parameter logic [7:0]  CMD_LOAD     = 8'h4C,
  parameter logic [7:0]  CMD_RUN      = 8'h52,
  parameter logic [7:0]  CMD_STEP     = 8'h53,
  parameter logic [7:0]  CMD_EXIT     = 8'h45
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_done,
  input  logic             i_load_done,
  input  logic             i_halt,
  input  logic             i_dump_done,
  output logic [2:0]       o_debug_state,
  output logic             o_load_start,
  output logic             o_loading,
  output logic             o_cpu_enable,
  output logic             o_cpu_reset,
  output logic             o_dump_start,
  output logic [CNT_W-1:0] o_cycle_count,
  output logic             o_error
);

  // state      | meaning
  // IDLE       | waiting for a command byte
  // START_LOAD | pulse loader start, invalidate program
  // WAIT_LOAD  | rx bytes go to loader, watchdog running
  // START_RUN  | CPU reset before free-run
  // WAIT_RUN   | CPU enabled until HALT
  // START_STEP | first entry: CPU reset; later: one enable cycle
  // WAIT_STEP  | waiting for next step or exit
  // DUMP       | register dump in progress
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_LOAD = 3'd1,
    WAIT_LOAD  = 3'd2,
    START_RUN  = 3'd3,
    WAIT_RUN   = 3'd4,
    START_STEP = 3'd5,
    WAIT_STEP  = 3'd6,
    DUMP       = 3'd7
  } state_t;

  localparam int TO_W = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOAD_TIMEOUT - 1);

  state_t          state, state_nxt;
  logic            loaded, loaded_nxt;
  logic            first_step, first_step_nxt;
  logic            from_run, from_run_nxt;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic            err_nxt, dump_start_nxt;
  logic            cpu_reset_c, cpu_enable_c;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state         <= IDLE;
      loaded        <= 1'b0;
      first_step    <= 1'b0;
      from_run      <= 1'b0;
      to_cnt        <= '0;
      o_error       <= 1'b0;
      o_dump_start  <= 1'b0;
      o_cycle_count <= '0;
    end else begin
      state        <= state_nxt;
      loaded       <= loaded_nxt;
      first_step   <= first_step_nxt;
      from_run     <= from_run_nxt;
      to_cnt       <= to_cnt_nxt;
      o_error      <= err_nxt;
      o_dump_start <= dump_start_nxt;
      if (cpu_reset_c)
        o_cycle_count <= '0;
      else if (cpu_enable_c && !(&o_cycle_count))
        o_cycle_count <= o_cycle_count + 1'b1;
    end
  end

  always_comb begin
    state_nxt      = state;
    loaded_nxt     = loaded;
    first_step_nxt = first_step;
    from_run_nxt   = from_run;
    to_cnt_nxt     = '0;
    err_nxt        = 1'b0;
    cpu_reset_c    = 1'b0;
    cpu_enable_c   = 1'b0;
    case (state)
      IDLE: begin
        if (i_rx_done) begin
          if (i_rx_data == CMD_LOAD) begin
            state_nxt = START_LOAD;
          end else if (i_rx_data == CMD_RUN) begin
            if (loaded) state_nxt = START_RUN;
            else        err_nxt   = 1'b1;
          end else if (i_rx_data == CMD_STEP) begin
            if (loaded) begin
              state_nxt      = START_STEP;
              first_step_nxt = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end
      end
      START_LOAD: begin
        loaded_nxt = 1'b0;
        state_nxt  = WAIT_LOAD;
      end
      WAIT_LOAD: begin
        to_cnt_nxt = i_rx_done ? '0 : to_cnt + 1'b1;
        // a finished load beats a watchdog expiry in the same cycle
        if (i_load_done) begin
          loaded_nxt = 1'b1;
          state_nxt  = IDLE;
        end else if (to_cnt == TO_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      START_RUN: begin
        cpu_reset_c  = 1'b1;
        from_run_nxt = 1'b1;
        state_nxt    = WAIT_RUN;
      end
      WAIT_RUN: begin
        cpu_enable_c = ~i_halt;
        if (i_halt) state_nxt = DUMP;
      end
      START_STEP: begin
        if (first_step) begin
          cpu_reset_c    = 1'b1;
          first_step_nxt = 1'b0;
          from_run_nxt   = 1'b0;
          state_nxt      = WAIT_STEP;
        end else begin
          cpu_enable_c = 1'b1;
          state_nxt    = DUMP;
        end
      end
      WAIT_STEP: begin
        if (i_rx_done) begin
          if (i_rx_data == CMD_STEP)      state_nxt = START_STEP;
          else if (i_rx_data == CMD_EXIT) state_nxt = IDLE;
        end
      end
      DUMP: begin
        if (i_dump_done) state_nxt = (from_run || i_halt) ? IDLE : WAIT_STEP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dump_start_nxt = (state_nxt == DUMP) && (state != DUMP);

  assign o_debug_state = state;
  assign o_load_start  = (state == START_LOAD);
  assign o_loading     = (state == WAIT_LOAD);
  assign o_cpu_reset   = cpu_reset_c;
  assign o_cpu_enable  = cpu_enable_c;

endmodule

// File: tb/tb_debug_unit_fsm.sv
// Directed bench for debug_unit_fsm with a short load watchdog (16 clocks).
module tb_debug_unit_fsm;

  localparam int CNT_W = 32;

  logic             i_clock = 1'b0;
  logic             i_reset = 1'b0;
  logic [7:0]       i_rx_data = 8'h00;
  logic             i_rx_done = 1'b0;
  logic             i_load_done = 1'b0;
  logic             i_halt = 1'b0;
  logic             i_dump_done = 1'b0;
  logic [2:0]       o_debug_state;
  logic             o_load_start, o_loading, o_cpu_enable, o_cpu_reset;
  logic             o_dump_start, o_error;
  logic [CNT_W-1:0] o_cycle_count;

  int n_checks = 0;
  int n_errors = 0;
  int en_hits;

  debug_unit_fsm #(.CNT_W(CNT_W), .LOAD_TIMEOUT(16)) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_rx_data    (i_rx_data),
    .i_rx_done    (i_rx_done),
    .i_load_done  (i_load_done),
    .i_halt       (i_halt),
    .i_dump_done  (i_dump_done),
    .o_debug_state(o_debug_state),
    .o_load_start (o_load_start),
    .o_loading    (o_loading),
    .o_cpu_enable (o_cpu_enable),
    .o_cpu_reset  (o_cpu_reset),
    .o_dump_start (o_dump_start),
    .o_cycle_count(o_cycle_count),
    .o_error      (o_error)
  );

  always #5 i_clock = ~i_clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    tick();
    i_rx_done = 1'b0;
  endtask

  task automatic do_load();
    send(8'h4C);
    check_eq("ld_state1", o_debug_state, 1);
    check_eq("ld_start", o_load_start, 1);
    tick();
    check_eq("ld_state2", o_debug_state, 2);
    check_eq("ld_loading", o_loading, 1);
    check_eq("ld_start_gone", o_load_start, 0);
    tick();
    tick();
    i_load_done = 1'b1;
    tick();
    i_load_done = 1'b0;
    check_eq("ld_done_idle", o_debug_state, 0);
    check_eq("ld_no_err", o_error, 0);
  endtask

  initial begin
    #12;
    check_eq("rst_state", o_debug_state, 0);
    check_eq("rst_en", o_cpu_enable, 0);
    check_eq("rst_cnt", o_cycle_count, 0);
    i_reset = 1'b1;
    tick();

    // run without a program
    send(8'h52);
    check_eq("unl_run_err", o_error, 1);
    check_eq("unl_run_state", o_debug_state, 0);
    check_eq("unl_run_en", o_cpu_enable, 0);
    tick();
    check_eq("unl_err_1cyc", o_error, 0);

    // load watchdog expiry
    send(8'h4C);
    tick();
    check_eq("to_enter", o_debug_state, 2);
    for (int i = 0; i < 15; i++) begin
      tick();
      check_eq("to_waiting", {o_debug_state, o_error}, {3'd2, 1'b0});
    end
    tick();
    check_eq("to_state", o_debug_state, 0);
    check_eq("to_err", o_error, 1);
    tick();
    check_eq("to_err_1cyc", o_error, 0);
    send(8'h53);
    check_eq("to_step_err", o_error, 1);
    check_eq("to_step_state", o_debug_state, 0);

    // normal load then free-run for 10 enabled cycles
    do_load();
    send(8'h52);
    check_eq("run_state3", o_debug_state, 3);
    check_eq("run_cpu_rst", o_cpu_reset, 1);
    check_eq("run_en0", o_cpu_enable, 0);
    tick();
    check_eq("run_state4", o_debug_state, 4);
    check_eq("run_rst_gone", o_cpu_reset, 0);
    check_eq("run_en1", o_cpu_enable, 1);
    for (int i = 0; i < 10; i++) tick();
    check_eq("run_cnt10", o_cycle_count, 10);
    check_eq("run_still4", o_debug_state, 4);
    i_halt = 1'b1;
    #1;
    check_eq("run_halt_en", o_cpu_enable, 0);
    tick();
    check_eq("run_dump_state", o_debug_state, 7);
    check_eq("run_dump_start", o_dump_start, 1);
    check_eq("run_cnt_hold", o_cycle_count, 10);
    tick();
    check_eq("run_dump_1cyc", o_dump_start, 0);
    i_dump_done = 1'b1;
    tick();
    i_dump_done = 1'b0;
    i_halt = 1'b0;
    check_eq("run_back_idle", o_debug_state, 0);

    // single-step: first step resets, then three stepped cycles
    send(8'h53);
    check_eq("st_state5", o_debug_state, 5);
    check_eq("st_cpu_rst", o_cpu_reset, 1);
    check_eq("st_en0", o_cpu_enable, 0);
    tick();
    check_eq("st_state6", o_debug_state, 6);
    check_eq("st_cnt0", o_cycle_count, 0);
    en_hits = 0;
    for (int i = 0; i < 3; i++) begin
      send(8'h53);
      check_eq("st_go", o_debug_state, 5);
      if (o_cpu_enable) en_hits++;
      tick();
      if (o_cpu_enable) en_hits++;
      check_eq("st_dump", {o_debug_state, o_dump_start}, {3'd7, 1'b1});
      if (i != 0) begin
        tick();
        if (o_cpu_enable) en_hits++;
        check_eq("st_dump_wait", {o_debug_state, o_dump_start}, {3'd7, 1'b0});
      end
      i_dump_done = 1'b1;
      tick();
      i_dump_done = 1'b0;
      if (o_cpu_enable) en_hits++;
      check_eq("st_back6", o_debug_state, 6);
    end
    check_eq("st_en_pulses", en_hits, 3);
    check_eq("st_cnt3", o_cycle_count, 3);
    send(8'h52);
    check_eq("st_ignore_run", o_debug_state, 6);
    send(8'h45);
    check_eq("st_exit", o_debug_state, 0);

    // step while already halted still enables once, then returns to idle
    send(8'h53);
    tick();
    i_halt = 1'b1;
    send(8'h53);
    check_eq("hs_en", o_cpu_enable, 1);
    tick();
    check_eq("hs_dump", o_debug_state, 7);
    i_dump_done = 1'b1;
    tick();
    i_dump_done = 1'b0;
    i_halt = 1'b0;
    check_eq("hs_idle", o_debug_state, 0);
    check_eq("hs_cnt1", o_cycle_count, 1);

    // load_done on the same cycle as watchdog expiry wins
    send(8'h4C);
    tick();
    for (int i = 0; i < 15; i++) tick();
    i_load_done = 1'b1;
    tick();
    i_load_done = 1'b0;
    check_eq("tie_state", o_debug_state, 0);
    check_eq("tie_no_err", o_error, 0);
    send(8'h52);
    check_eq("tie_loaded", o_debug_state, 3);
    tick();
    tick();
    tick();
    check_eq("mid_run", o_debug_state, 4);

    // async reset mid-run
    #2;
    i_reset = 1'b0;
    #1;
    check_eq("ar_state", o_debug_state, 0);
    check_eq("ar_en", o_cpu_enable, 0);
    check_eq("ar_cnt", o_cycle_count, 0);
    tick();
    i_reset = 1'b1;
    tick();
    send(8'h52);
    check_eq("ar_unloaded_err", o_error, 1);
    check_eq("ar_state_idle", o_debug_state, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
